// File: rtl/wb_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_sched_pkg : shared types and constants for the writeback       |
// | scheduler (register addressing, requester identities).            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package wb_sched_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  // x0 is hardwired to zero, so writes to it are never real regfile writes.
  function automatic logic is_wb_target(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_sched_if : writeback, issue, scoreboard-query and regfile      |
// | write-port signals. WB_SCHED_BYPASS_EN adds forwarding outputs.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface wb_sched_if #(
  parameter int XLEN = 32
);
  import wb_sched_pkg::*;

  logic            alu_valid;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  reg_addr_t       lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            iss_valid;
  reg_addr_t       iss_rd;
  logic            iss_ready;

  reg_addr_t       rs1;
  reg_addr_t       rs2;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            rd_w;
  reg_addr_t       rd;
  logic [XLEN-1:0] rd_in;

`ifdef WB_SCHED_BYPASS_EN
  logic            rs1_fwd;
  logic            rs2_fwd;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
    input  rd_w, rd, rd_in, rs1_fwd, rs2_fwd, fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
    output rd_w, rd, rd_in, rs1_fwd, rs2_fwd, fwd_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
    input  rd_w, rd, rd_in
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
    output rd_w, rd, rd_in
  );
`endif

endinterface
`default_nettype wire

// File: rtl/wb_rr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_rr_arb : two-way round-robin arbiter for the regfile write    |
// | port; after reset the ALU wins the first contention.             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module wb_rr_arb
  import wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_e r_last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (r_last_grant == REQ_LSU) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= REQ_LSU;
    end else if (gnt[REQ_ALU]) begin
      r_last_grant <= REQ_ALU;
    end else if (gnt[REQ_LSU]) begin
      r_last_grant <= REQ_LSU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_sched : regfile write-port scheduler (ALU/LSU round-robin) and |
// | per-register busy scoreboard. Option macro: WB_SCHED_BYPASS_EN.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  wb_sched_if.slave bus
);

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                r_rd_w;
  reg_addr_t           r_rd;
  logic [XLEN-1:0]     r_rd_in;
  logic [NUM_REGS-1:1] r_busy;
  logic [NUM_REGS-1:0] w_busy;
  logic                w_iss_ready;
  logic                w_iss_fire;

  // Zero-destination requests bypass arbitration entirely.
  assign w_req[REQ_ALU] = ~rst & bus.alu_valid & is_wb_target(bus.alu_rd);
  assign w_req[REQ_LSU] = ~rst & bus.lsu_valid & is_wb_target(bus.lsu_rd);

  wb_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .gnt (w_gnt)
  );

  assign bus.alu_ready = ~rst & (~is_wb_target(bus.alu_rd) | w_gnt[REQ_ALU]);
  assign bus.lsu_ready = ~rst & (~is_wb_target(bus.lsu_rd) | w_gnt[REQ_LSU]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_w  <= 1'b0;
      r_rd    <= '0;
      r_rd_in <= '0;
    end else begin
      r_rd_w <= |w_gnt;
      if (w_gnt[REQ_ALU]) begin
        r_rd    <= bus.alu_rd;
        r_rd_in <= bus.alu_data;
      end else if (w_gnt[REQ_LSU]) begin
        r_rd    <= bus.lsu_rd;
        r_rd_in <= bus.lsu_data;
      end
    end
  end

  assign bus.rd_w  = r_rd_w;
  assign bus.rd    = r_rd;
  assign bus.rd_in = r_rd_in;

  assign w_busy      = {r_busy, 1'b0};
  assign w_iss_ready = ~w_busy[bus.iss_rd];
  assign w_iss_fire  = bus.iss_valid & w_iss_ready & is_wb_target(bus.iss_rd);
  assign bus.iss_ready = w_iss_ready;

  // Busy clears on the regfile commit edge; a same-cycle issue to it wins.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_busy
    logic w_set;
    logic w_clr;

    assign w_set = w_iss_fire & (bus.iss_rd == reg_addr_t'(g));
    assign w_clr = r_rd_w & (r_rd == reg_addr_t'(g));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_busy[g] <= 1'b0;
      end else if (w_set) begin
        r_busy[g] <= 1'b1;
      end else if (w_clr) begin
        r_busy[g] <= 1'b0;
      end
    end
  end

`ifdef WB_SCHED_BYPASS_EN
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit    = r_rd_w & (r_rd == bus.rs1);
  assign w_rs2_hit    = r_rd_w & (r_rd == bus.rs2);
  assign bus.rs1_busy = w_busy[bus.rs1] & ~w_rs1_hit;
  assign bus.rs2_busy = w_busy[bus.rs2] & ~w_rs2_hit;
  assign bus.rs1_fwd  = w_rs1_hit & is_wb_target(bus.rs1);
  assign bus.rs2_fwd  = w_rs2_hit & is_wb_target(bus.rs2);
  assign bus.fwd_data = r_rd_in;
`else
  assign bus.rs1_busy = w_busy[bus.rs1];
  assign bus.rs2_busy = w_busy[bus.rs2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_sched : directed scenarios plus randomized traffic against  |
// | a behavioural scoreboard/arbiter model. Honours WB_SCHED_BYPASS_EN|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_wb_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #50 clk = ~clk;

  wb_sched_if #(.XLEN(32)) bus ();

  wb_sched #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hAAAA;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h5555;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rd_w !== 1'b0) begin errors++; $display("FAIL reset_rd_w: got %b expected 0", bus.rd_w); end
    checks++; if (bus.rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", bus.rd); end
    checks++; if (bus.rd_in !== 32'd0) begin errors++; $display("FAIL reset_rd_in: got %0h expected 0", bus.rd_in); end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", bus.alu_ready); end
    checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %b expected 0", bus.lsu_ready); end
    for (int r = 1; r < 32; r++) begin
      bus.rs1 = 5'(r); bus.rs2 = 5'(r); bus.iss_rd = 5'(r);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.iss_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_busy[%0d]: got rs1_busy=%b rs2_busy=%b iss_ready=%b expected 0 0 1",
                 r, bus.rs1_busy, bus.rs2_busy, bus.iss_ready);
      end
    end
  endtask

  // Continues straight out of test_reset with both requesters still valid.
  task automatic test_contention();
    logic exp_alu;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_alu = (i % 2 == 0);
      checks++;
      if (bus.alu_ready !== exp_alu || bus.lsu_ready !== !exp_alu) begin
        errors++;
        $display("FAIL contention_ready[%0d]: got alu=%b lsu=%b expected alu=%b lsu=%b",
                 i, bus.alu_ready, bus.lsu_ready, exp_alu, !exp_alu);
      end
      tick();
      checks++;
      if (bus.rd_w !== 1'b1 || bus.rd !== (exp_alu ? 5'd5 : 5'd6) ||
          bus.rd_in !== (exp_alu ? 32'hAAAA : 32'h5555)) begin
        errors++;
        $display("FAIL contention_write[%0d]: got w=%b rd=%0d data=%0h expected w=1 rd=%0d data=%0h",
                 i, bus.rd_w, bus.rd, bus.rd_in, exp_alu ? 5 : 6, exp_alu ? 32'hAAAA : 32'h5555);
      end
    end
    idle();
    tick();
    checks++;
    if (bus.rd_w !== 1'b0 || bus.rd !== 5'd6 || bus.rd_in !== 32'h5555) begin
      errors++;
      $display("FAIL contention_hold: got w=%b rd=%0d data=%0h expected w=0 rd=6 data=5555",
               bus.rd_w, bus.rd, bus.rd_in);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_b;
    do_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sb_iss_free: got %b expected 1", bus.iss_ready); end
    tick();
    bus.iss_valid = 1'b0; bus.rs1 = 5'd7;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_set: got %b expected 1", bus.rs1_busy); end
    checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_stall: got %b expected 0", bus.iss_ready); end
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_hold: got %b expected 1", bus.rs1_busy); end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL sb_alu_ready: got %b expected 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++;
    if (bus.rd_w !== 1'b1 || bus.rd !== 5'd7 || bus.rd_in !== 32'h77) begin
      errors++;
      $display("FAIL sb_write: got w=%b rd=%0d data=%0h expected w=1 rd=7 data=77", bus.rd_w, bus.rd, bus.rd_in);
    end
`ifdef WB_SCHED_BYPASS_EN
    exp_b = 1'b0;
    checks++; if (bus.rs1_fwd !== 1'b1) begin errors++; $display("FAIL sb_fwd: got %b expected 1", bus.rs1_fwd); end
`else
    exp_b = 1'b1;
`endif
    checks++; if (bus.rs1_busy !== exp_b) begin errors++; $display("FAIL sb_busy_commit_cycle: got %b expected %b", bus.rs1_busy, exp_b); end
    checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL sb_iss_commit_cycle: got %b expected 0", bus.iss_ready); end
    tick();
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.iss_ready !== 1'b1 || bus.rd_w !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: got busy=%b iss_ready=%b w=%b expected 0 1 0", bus.rs1_busy, bus.iss_ready, bus.rd_w);
    end
  endtask

  task automatic test_zero_dest();
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h333;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hDEAD;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_both_ready: got alu=%b lsu=%b expected 1 1", bus.alu_ready, bus.lsu_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++;
    if (bus.rd_w !== 1'b1 || bus.rd !== 5'd3 || bus.rd_in !== 32'h333) begin
      errors++;
      $display("FAIL zero_write: got w=%b rd=%0d data=%0h expected w=1 rd=3 data=333", bus.rd_w, bus.rd, bus.rd_in);
    end
    tick();
    checks++; if (bus.rd_w !== 1'b0) begin errors++; $display("FAIL zero_no_write: got %b expected 0", bus.rd_w); end
    // last_grant is now ALU; the accepted x0 write must not have moved it.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'h1111;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'h1212;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_last_grant: got alu=%b lsu=%b expected 0 1", bus.alu_ready, bus.lsu_ready);
    end
    tick();
    idle();
    checks++; if (bus.rd !== 5'd12) begin errors++; $display("FAIL zero_lsu_write: got rd=%0d expected 12", bus.rd); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd10;
    tick();
    bus.iss_rd = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL mid_alu_ready: got %b expected 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rs1 = 5'd9; bus.rs2 = 5'd10;
    #1;
    checks++;
    if (bus.rd_w !== 1'b0 || bus.rd !== 5'd0 || bus.rd_in !== 32'd0) begin
      errors++;
      $display("FAIL mid_write_dropped: got w=%b rd=%0d data=%0h expected 0 0 0", bus.rd_w, bus.rd, bus.rd_in);
    end
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy_cleared: got rs1=%b rs2=%b expected 0 0", bus.rs1_busy, bus.rs2_busy);
    end
  endtask

`ifdef WB_SCHED_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    tick();
    bus.iss_valid = 1'b0;
    bus.rs2 = 5'd4;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h1234;
    #1;
    checks++; if (bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL byp_pending: got %b expected 1", bus.rs2_busy); end
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    checks++;
    if (bus.rs2_busy !== 1'b0 || bus.rs2_fwd !== 1'b1 || bus.fwd_data !== 32'h1234 || bus.rs1_fwd !== 1'b0) begin
      errors++;
      $display("FAIL byp_forward: got busy=%b fwd=%b data=%0h rs1_fwd=%b expected 0 1 1234 0",
               bus.rs2_busy, bus.rs2_fwd, bus.fwd_data, bus.rs1_fwd);
    end
  endtask
`endif

  // Requesters hold their request until accepted; decode issues freely.
  task automatic test_random();
    bit [31:0] m_busy;
    bit        m_last_lsu;
    bit        m_wv;
    bit [4:0]  m_wrd;
    bit [31:0] m_wdata;
    bit        a_pend, l_pend, a_req, l_req, win_a, win_l, e_iss, e_b1, e_b2;
    bit [4:0]  a_rd, l_rd;
    bit [31:0] a_dat, l_dat;
    do_reset();
    m_busy = '0; m_last_lsu = 1'b1; m_wv = 1'b0; m_wrd = '0; m_wdata = '0;
    a_pend = 1'b0; l_pend = 1'b0; a_rd = '0; l_rd = '0; a_dat = '0; l_dat = '0;
    for (int c = 0; c < 600; c++) begin
      if (!a_pend && $urandom_range(0, 1) == 1) begin
        a_pend = 1'b1; a_rd = 5'($urandom_range(0, 9)); a_dat = $urandom;
      end
      if (!l_pend && $urandom_range(0, 1) == 1) begin
        l_pend = 1'b1; l_rd = 5'($urandom_range(0, 9)); l_dat = $urandom;
      end
      bus.alu_valid = a_pend; bus.alu_rd = a_rd; bus.alu_data = a_dat;
      bus.lsu_valid = l_pend; bus.lsu_rd = l_rd; bus.lsu_data = l_dat;
      bus.iss_valid = ($urandom_range(0, 2) == 0);
      bus.iss_rd = 5'($urandom_range(0, 9));
      bus.rs1 = 5'($urandom_range(0, 9));
      bus.rs2 = 5'($urandom_range(0, 9));
      #1;
      a_req = a_pend && a_rd != 0;
      l_req = l_pend && l_rd != 0;
      win_a = a_req && (!l_req || m_last_lsu);
      win_l = l_req && (!a_req || !m_last_lsu);
      e_iss = !m_busy[bus.iss_rd];
      e_b1  = m_busy[bus.rs1];
      e_b2  = m_busy[bus.rs2];
`ifdef WB_SCHED_BYPASS_EN
      if (m_wv && m_wrd == bus.rs1) e_b1 = 1'b0;
      if (m_wv && m_wrd == bus.rs2) e_b2 = 1'b0;
      checks++;
      if (bus.rs1_fwd !== (m_wv && m_wrd == bus.rs1 && bus.rs1 != 0) ||
          bus.rs2_fwd !== (m_wv && m_wrd == bus.rs2 && bus.rs2 != 0) ||
          (m_wv && bus.fwd_data !== m_wdata)) begin
        errors++;
        $display("FAIL rnd_fwd[%0d]: got fwd1=%b fwd2=%b data=%0h model wv=%b wrd=%0d wdata=%0h",
                 c, bus.rs1_fwd, bus.rs2_fwd, bus.fwd_data, m_wv, m_wrd, m_wdata);
      end
`endif
      checks++;
      if (a_pend && bus.alu_ready !== (a_rd == 0 || win_a)) begin
        errors++; $display("FAIL rnd_alu_ready[%0d]: got %b expected %b", c, bus.alu_ready, (a_rd == 0 || win_a));
      end
      checks++;
      if (l_pend && bus.lsu_ready !== (l_rd == 0 || win_l)) begin
        errors++; $display("FAIL rnd_lsu_ready[%0d]: got %b expected %b", c, bus.lsu_ready, (l_rd == 0 || win_l));
      end
      checks++;
      if (bus.iss_ready !== e_iss || bus.rs1_busy !== e_b1 || bus.rs2_busy !== e_b2) begin
        errors++;
        $display("FAIL rnd_scoreboard[%0d]: got iss=%b b1=%b b2=%b expected %b %b %b",
                 c, bus.iss_ready, bus.rs1_busy, bus.rs2_busy, e_iss, e_b1, e_b2);
      end
      checks++;
      if (bus.rd_w !== m_wv || bus.rd !== m_wrd || bus.rd_in !== m_wdata) begin
        errors++;
        $display("FAIL rnd_write[%0d]: got w=%b rd=%0d data=%0h expected %b %0d %0h",
                 c, bus.rd_w, bus.rd, bus.rd_in, m_wv, m_wrd, m_wdata);
      end
      if (m_wv) m_busy[m_wrd] = 1'b0;
      if (bus.iss_valid && e_iss && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      if (win_a) begin
        m_wv = 1'b1; m_wrd = a_rd; m_wdata = a_dat; m_last_lsu = 1'b0;
      end else if (win_l) begin
        m_wv = 1'b1; m_wrd = l_rd; m_wdata = l_dat; m_last_lsu = 1'b1;
      end else begin
        m_wv = 1'b0;
      end
      if (a_pend && (a_rd == 0 || win_a)) a_pend = 1'b0;
      if (l_pend && (l_rd == 0 || win_l)) l_pend = 1'b0;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_contention();
    test_scoreboard();
    test_zero_dest();
    test_reset_mid();
`ifdef WB_SCHED_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
